alu_seq: RTL and testbench

//  Parametrised, handshaked successor of the single-cycle execute ALU. Computes the RV32I

---
 rtl/alu_seq.sv | 177 +++++++++++++++++
 tb/tb_alu_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked RV32I execute ALU with a registered result and one-deep output hold.
// Define ALU_MULDIV_EN to build the iterative RV-M multiply/divide unit (BUSY state).
module alu_seq #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic            is_muldiv,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

`ifdef ALU_MULDIV_EN
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
`else
    typedef enum logic {IDLE = 1'b0} state_t;
`endif

    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b1000, OP_SLL = 4'b0001,
                           OP_SLT = 4'b0010, OP_SLTU = 4'b0011, OP_XOR = 4'b0100,
                           OP_SRL = 4'b0101, OP_SRA = 4'b1101, OP_OR = 4'b0110,
                           OP_AND = 4'b0111;

    state_t             state, state_d;
    logic               accept;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_res;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush && !rst;
    assign accept   = in_valid && in_ready;
    assign shamt    = data2[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = data1 + data2;
            OP_SUB:  alu_res = data1 - data2;
            OP_SLL:  alu_res = data1 << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(data1) < $signed(data2)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, data1 < data2};
            OP_XOR:  alu_res = data1 ^ data2;
            OP_SRL:  alu_res = data1 >> shamt;
            OP_SRA:  alu_res = $signed(data1) >>> shamt;
            OP_OR:   alu_res = data1 | data2;
            OP_AND:  alu_res = data1 & data2;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam int CNT_W = $clog2(XLEN);

    logic [CNT_W-1:0]  count;
    logic [2:0]        md_op_q;
    logic [XLEN-1:0]   opnd, hi, lo, hi_d, lo_d, dividend, md_res, mag_a, mag_b;
    logic              neg_q, rem_neg_q, div_zero_q, a_signed, b_signed, neg_a, neg_b, done;
    logic [XLEN:0]     sum, trial, diff;
    logic [2*XLEN-1:0] prod;

    assign done = (state == BUSY) && (count == CNT_W'(XLEN - 1));

    // Both units work on magnitudes; the sign is restored once on completion.
    always_comb begin
        a_signed = (md_op == 3'd1) || (md_op == 3'd2) || (md_op == 3'd4) || (md_op == 3'd6);
        b_signed = (md_op == 3'd1) || (md_op == 3'd4) || (md_op == 3'd6);
        neg_a    = a_signed && data1[XLEN-1];
        neg_b    = b_signed && data2[XLEN-1];
        mag_a    = neg_a ? -data1 : data1;
        mag_b    = neg_b ? -data2 : data2;
    end

    // {hi,lo} is the shift-add product for multiply and {remainder,quotient} for divide.
    always_comb begin
        sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        trial = {hi, lo[XLEN-1]};
        diff  = trial - {1'b0, opnd};
        if (md_op_q[2]) begin
            if (!diff[XLEN]) begin
                hi_d = diff[XLEN-1:0];
                lo_d = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_d = trial[XLEN-1:0];
                lo_d = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo[XLEN-1:1]};
        end
        prod = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
        case (md_op_q)
            3'd0:          md_res = prod[XLEN-1:0];
            3'd4, 3'd5:    md_res = div_zero_q ? '1 : (neg_q ? -lo_d : lo_d);
            3'd6, 3'd7:    md_res = div_zero_q ? dividend : (rem_neg_q ? -hi_d : hi_d);
            default:       md_res = prod[2*XLEN-1:XLEN];
        endcase
    end

    // NOTE: operand/accumulator registers have no reset; they are always loaded on accept
    // before use, and only the control state needs a known value.
    always_ff @(posedge clk) begin
        if (accept && is_muldiv) begin
            md_op_q    <= md_op;
            opnd       <= mag_b;
            hi         <= '0;
            lo         <= mag_a;
            neg_q      <= neg_a ^ neg_b;
            rem_neg_q  <= neg_a;
            div_zero_q <= (data2 == '0);
            dividend   <= data1;
        end else if (state == BUSY) begin
            hi <= hi_d;
            lo <= lo_d;
        end
    end
`else
    logic unused_md;
    assign unused_md = ^md_op;
`endif

    always_comb begin
        state_d = state;
`ifdef ALU_MULDIV_EN
        case (state)
            IDLE:    if (accept && is_muldiv) state_d = BUSY;
            BUSY:    if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`endif
        if (flush) state_d = IDLE;
    end

    // NOTE: all sequential state uses non-blocking assignment so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
`ifdef ALU_MULDIV_EN
            count     <= '0;
`endif
        end else begin
            state <= state_d;
            if (flush) begin
                out_valid <= 1'b0;
`ifdef ALU_MULDIV_EN
            end else if (done) begin
                out_valid <= 1'b1;
                result    <= md_res;
            end else if (accept && !is_muldiv) begin
                out_valid <= 1'b1;
                result    <= alu_res;
`else
            end else if (accept) begin
                out_valid <= 1'b1;
                result    <= is_muldiv ? '0 : alu_res;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef ALU_MULDIV_EN
            if (flush || done || (accept && is_muldiv)) count <= '0;
            else if (state == BUSY)                     count <= count + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed stimulus pushes expected results and due cycles;
// a negedge monitor pops and compares on every output transfer.
module tb_alu_seq;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, is_muldiv, out_valid, out_ready;
    logic [3:0]      alu_op;
    logic [2:0]      md_op;
    logic [XLEN-1:0] data1, data2, result;

    alu_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .is_muldiv(is_muldiv), .md_op(md_op), .data1(data1), .data2(data2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          due;
        bit          exact;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check(mon_e.name, result, mon_e.data);
                if (mon_e.exact) check({mon_e.name, "_cycle"}, cyc, mon_e.due);
                else             check({mon_e.name, "_late"}, {31'b0, cyc >= mon_e.due}, 32'd1);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the request.
    task automatic issue(input string name, input logic md, input logic [3:0] op,
                         input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit exact,
                         input bit push, output int acc);
        exp_t e;
        int   n = 0;
        bit   got = 0;
        acc = -1;
        in_valid = 1'b1; is_muldiv = md; alu_op = op; md_op = mop; data1 = a; data2 = b;
        while (!got && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                acc = cyc;
                if (push) begin
                    e.data = exp; e.due = cyc + lat; e.exact = exact; e.name = name;
                    sb.push_back(e);
                end
            end else begin
                @(posedge clk); #1;
            end
            n++;
        end
        if (got) begin
            @(posedge clk); #1;
        end else begin
            check({name, "_accept_timeout"}, 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    int acc, t0, n;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; is_muldiv = 1'b0;
        alu_op = 4'd0; md_op = 3'd0; data1 = '0; data2 = '0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_out_valid", {31'b0, out_valid}, 32'd0);
            check("rst_result", result, 32'd0);
            check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        end
        rst = 1'b0;
        #1 check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Back-to-back base ops, one result per cycle.
        issue("add_ovf", 0, 4'b0000, 3'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 1, 1, acc);
        issue("sra_4", 0, 4'b1101, 3'd0, 32'h8000_0000, 32'h24, 32'hF800_0000, 1, 1, 1, acc);
        issue("sltu", 0, 4'b0011, 3'd0, 32'h1, 32'hFFFF_FFFF, 32'h1, 1, 1, 1, acc);
        issue("slt_neg", 0, 4'b0010, 3'd0, 32'hFFFF_FFFF, 32'h1, 32'h1, 1, 1, 1, acc);
        issue("sll_mask", 0, 4'b0001, 3'd0, 32'h1, 32'h21, 32'h2, 1, 1, 1, acc);
        issue("srl_4", 0, 4'b0101, 3'd0, 32'h8000_0000, 32'h4, 32'h0800_0000, 1, 1, 1, acc);
        issue("xor", 0, 4'b0100, 3'd0, 32'hF0F0, 32'hFF00, 32'h0FF0, 1, 1, 1, acc);
        issue("or", 0, 4'b0110, 3'd0, 32'hF0F0, 32'hFF00, 32'hFFF0, 1, 1, 1, acc);
        issue("and", 0, 4'b0111, 3'd0, 32'hF0F0, 32'hFF00, 32'hF000, 1, 1, 1, acc);
        issue("bad_op", 0, 4'b1111, 3'd0, 32'h1234, 32'h5678, 32'h0, 1, 1, 1, acc);

        // Output back-pressure: result and out_valid hold, no new accept.
        issue("sub_held", 0, 4'b1000, 3'd0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 0, 1, acc);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_result", result, 32'hFFFF_FFFE);
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        t0 = cyc;
        issue("and_after_hold", 0, 4'b0111, 3'd0, 32'hFF, 32'h0F, 32'h0F, 1, 1, 1, acc);
        check("accept_on_release", acc, t0);

`ifdef ALU_MULDIV_EN
        issue("mulh", 1, 4'd0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33, 1, 1, acc);
        issue("mulhu", 1, 4'd0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1, 1, acc);
        issue("mul", 1, 4'd0, 3'd0, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFF4, 33, 1, 1, acc);
        issue("mulhsu", 1, 4'd0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1, 1, acc);
        issue("div_ovf", 1, 4'd0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1, 1, acc);
        issue("rem_ovf", 1, 4'd0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33, 1, 1, acc);
        issue("remu_z", 1, 4'd0, 3'd7, 32'd7, 32'd0, 32'd7, 33, 1, 1, acc);
        issue("divu_z", 1, 4'd0, 3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF, 33, 1, 1, acc);
        issue("div_z", 1, 4'd0, 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 33, 1, 1, acc);
        issue("rem_neg", 1, 4'd0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1, 1, acc);
        issue("div_neg", 1, 4'd0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1, 1, acc);

        // Flush a DIV in its tenth busy cycle; a request offered alongside is ignored.
        issue("div_flushed", 1, 4'd0, 3'd4, 32'd100, 32'd7, 32'd14, 33, 1, 0, acc);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b1; is_muldiv = 1'b0; alu_op = 4'b0000; data1 = 32'd5; data2 = 32'd5;
        @(negedge clk);
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("in_ready_after_flush", {31'b0, in_ready}, 32'd1);
        issue("add_after_flush", 0, 4'b0000, 3'd0, 32'd1, 32'd1, 32'd2, 1, 1, 1, acc);
`else
        issue("mul_disabled", 1, 4'b0000, 3'd0, 32'd3, 32'd4, 32'd0, 1, 1, 1, acc);
        issue("add_after_mul", 0, 4'b0000, 3'd0, 32'd1, 32'd1, 32'd2, 1, 1, 1, acc);
`endif

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (50) @(posedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
